// File: rtl/pe_lin_pkg.sv
// Shared types and helpers for the linear weight-stationary PE row.
// Holds the row FSM state enum, default widths and the saturating-add helper.
package pe_lin_pkg;

  localparam int unsigned LANES_DEF = 4;
  localparam int unsigned DW_DEF    = 8;
  localparam int unsigned AW_DEF    = 12;
  localparam int unsigned SAT_MAXW  = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef logic [SAT_MAXW:0] sat_word_t;

  // Returns {overflow, value clamped to 2^aw-1}; aw must be below SAT_MAXW.
  function automatic sat_word_t sat_add(input logic [SAT_MAXW-1:0] acc,
                                        input logic [SAT_MAXW-1:0] prod,
                                        input int unsigned         aw);
    sat_word_t sum;
    sat_word_t lim;
    sum = {1'b0, acc} + {1'b0, prod};
    lim = (sat_word_t'(1) << aw) - sat_word_t'(1);
    if (sum > lim) sat_add = {1'b1, lim[SAT_MAXW-1:0]};
    else           sat_add = {1'b0, sum[SAT_MAXW-1:0]};
  endfunction

endpackage

// File: rtl/pe_lin_mac.sv
// One MAC lane: stationary weight register plus accumulator.
// PE_LIN_SAT_EN selects clamping to 2^AW-1 instead of wrapping.
module pe_lin_mac
  import pe_lin_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic [DW-1:0] i_w,
  input  logic          i_acc_en,
  input  logic          i_clr,
  input  logic [DW-1:0] i_a,
  output logic [AW-1:0] o_acc,
  output logic          o_ovf_c
);

  localparam int unsigned PW = 2 * DW;

  logic [DW-1:0] r_w;
  logic [AW-1:0] r_acc;
  logic [PW-1:0] w_prod;
  logic [AW-1:0] w_next;

  assign w_prod = PW'(r_w) * PW'(i_a);

`ifdef PE_LIN_SAT_EN
  sat_word_t w_sat;
  assign w_sat   = sat_add(SAT_MAXW'(r_acc), SAT_MAXW'(w_prod), AW);
  assign w_next  = AW'(w_sat);
  assign o_ovf_c = w_sat[SAT_MAXW];
`else
  localparam int unsigned SW = ((AW > PW) ? AW : PW) + 1;
  assign w_next  = AW'(SW'(r_acc) + SW'(w_prod));
  assign o_ovf_c = 1'b0;
`endif

  // Clear has priority; the row never asserts clr and acc_en together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_w   <= '0;
      r_acc <= '0;
    end else begin
      if (i_load) r_w <= i_w;
      if (i_clr)         r_acc <= '0;
      else if (i_acc_en) r_acc <= w_next;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/pe_lin_row.sv
// Linear PE row: LANES weight-stationary MAC lanes fed by one broadcast activation stream,
// framed by a_last and drained with backpressure. Optional clamping via PE_LIN_SAT_EN.
module pe_lin_row
  import pe_lin_pkg::*;
#(
  parameter int unsigned LANES = LANES_DEF,
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned AW    = AW_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                w_load,
  input  logic [LANES*DW-1:0] w_in,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [DW-1:0]       a_data,
  input  logic                a_last,
  output logic                o_valid,
  input  logic                o_ready,
  output logic [LANES*AW-1:0] o_data,
  output logic                sat
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_a_ready;
  logic             w_acc_en;
  logic             w_clr;
  logic             w_load_en;
  logic [LANES-1:0] w_ovf;
  logic             r_sat;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // A pending weight load blocks the beat, so weights never change under an accepted beat.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_en    = 1'b0;
    w_clr       = 1'b0;
    w_load_en   = 1'b0;
    w_a_ready   = (r_state != DRAIN) && !w_load;
    case (r_state)
      IDLE: begin
        w_load_en = w_load;
        if (a_valid && w_a_ready) begin
          w_acc_en    = 1'b1;
          w_state_nxt = a_last ? DRAIN : ACCUM;
        end
      end
      ACCUM: begin
        if (a_valid && w_a_ready) begin
          w_acc_en    = 1'b1;
          w_state_nxt = a_last ? DRAIN : ACCUM;
        end
      end
      DRAIN: begin
        if (o_ready) begin
          w_clr       = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Sticky per-frame overflow flag, cleared by the drain handshake.
  always_ff @(posedge clk) begin
    if (rst)                       r_sat <= 1'b0;
    else if (w_clr)                r_sat <= 1'b0;
    else if (w_acc_en && |w_ovf)   r_sat <= 1'b1;
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    pe_lin_mac #(
      .DW(DW),
      .AW(AW)
    ) u_mac (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_load_en),
      .i_w     (w_in[g*DW +: DW]),
      .i_acc_en(w_acc_en),
      .i_clr   (w_clr),
      .i_a     (a_data),
      .o_acc   (o_data[g*AW +: AW]),
      .o_ovf_c (w_ovf[g])
    );
  end

  assign a_ready = w_a_ready;
  assign o_valid = (r_state == DRAIN);
  assign sat     = r_sat;

endmodule
